// File: rtl/mac_requant.sv
// Requantization stage: adds a bias to a 2N-bit MAC accumulator, applies a rounding
// arithmetic right shift, optional ReLU, and saturates the result to N bits.
//
// Pipeline: S1 registers the exact (2N+1)-bit sum with its shift/relu controls;
// S2 is the output register. Valid/ready handshakes on both sides.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   acc_i, bias_i             signed 2N-bit accumulator and bias
//   shift_i                   unsigned right-shift amount (clamped to 2N)
//   relu_en_i                 zero negative results
//   acc_valid_i/acc_ready_o   input handshake
//   out_o                     signed N-bit requantized result
//   out_valid_o/out_ready_i   output handshake
//   sat_o                     sticky saturation flag, cleared by clear_sat_i
module mac_requant #(
  parameter int unsigned N       = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic signed [2*N-1:0] acc_i,
  input  logic signed [2*N-1:0] bias_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  input  logic                 relu_en_i,
  input  logic                 acc_valid_i,
  output logic                 acc_ready_o,
  output logic signed [N-1:0]  out_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 sat_o,
  input  logic                 clear_sat_i
);

  localparam int unsigned AW = 2 * N;   // accumulator width
  localparam int unsigned SW = AW + 1;  // exact sum width
  localparam int unsigned RW = AW + 2;  // rounding intermediate width

  localparam logic signed [RW-1:0] MaxVal = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [RW-1:0] MinVal = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};

  // Stage 1 state
  logic signed [SW-1:0]  sum_q, sum_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic                  relu_q, relu_d;
  logic                  s1_valid_q, s1_valid_d;

  // Stage 2 state
  logic signed [N-1:0]   out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sat_q, sat_d;

  logic                  s1_load, s2_load;

  // Requant datapath signals
  logic [31:0]           shift_ext, s_amt;
  logic signed [RW-1:0]  sum_ext, half, rnd, r_shift, r_relu;
  logic signed [N-1:0]   res;
  logic                  clamped;

  // Handshake: S2 frees up when empty or draining; S1 when empty or moving into S2.
  always_comb begin
    s2_load     = !out_valid_q || out_ready_i;
    s1_load     = !s1_valid_q || s2_load;
    acc_ready_o = s1_load;
  end

  // S1 next state: full-precision sum, never overflows at 2N+1 bits.
  always_comb begin
    sum_d      = sum_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = acc_valid_i;
      if (acc_valid_i) begin
        sum_d   = $signed({acc_i[AW-1], acc_i}) + $signed({bias_i[AW-1], bias_i});
        shift_d = shift_i;
        relu_d  = relu_en_i;
      end
    end
  end

  // Round half toward +inf, then ReLU, then saturate to N bits.
  always_comb begin
    shift_ext = 32'(shift_q);
    s_amt     = (shift_ext > AW) ? AW : shift_ext;
    sum_ext   = $signed({sum_q[SW-1], sum_q});
    half      = '0;
    if (s_amt != 0) begin
      half = $signed(RW'(1) << (s_amt - 32'd1));
    end
    rnd     = sum_ext + half;
    r_shift = rnd >>> s_amt;
    r_relu  = (relu_q && r_shift[RW-1]) ? '0 : r_shift;
    clamped = 1'b0;
    res     = r_relu[N-1:0];
    if (r_relu > MaxVal) begin
      res     = MaxVal[N-1:0];
      clamped = 1'b1;
    end else if (r_relu < MinVal) begin
      res     = MinVal[N-1:0];
      clamped = 1'b1;
    end
  end

  // S2 next state and sticky saturation flag (set beats clear).
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res;
      end
    end
    if (s2_load && s1_valid_q && clamped) begin
      sat_d = 1'b1;
    end else if (clear_sat_i) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign sat_o       = sat_q;

endmodule
